// File: rtl/store_pkg.sv
// Shared store-path definitions: size codes, controller states, lane masks.
// Used by the store-type decoder, store_align and store_ctrl.
package store_pkg;

    localparam logic [1:0] ST_SZ_W   = 2'b00;
    localparam logic [1:0] ST_SZ_H   = 2'b01;
    localparam logic [1:0] ST_SZ_B   = 2'b10;
    localparam logic [1:0] ST_SZ_ILL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Byte mask of an unshifted store of the given size.
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        logic [3:0] m;
        case (sz)
            ST_SZ_W: m = 4'b1111;
            ST_SZ_H: m = 4'b0011;
            ST_SZ_B: m = 4'b0001;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // True when the store spills into the next word.
    function automatic logic needs_split(
        input logic [1:0] sz,
        input logic [1:0] off
    );
        logic [7:0] be;
        be = {4'b0000, size_mask(sz)} << off;
        return |be[7:4];
    endfunction

endpackage

// File: rtl/store_ctrl_if.sv
// Store request handshake and data-memory write port bundle.
// slave = store_ctrl side, master = MEM stage / memory side.
interface store_ctrl_if #(
    parameter int AW = 32
);
    logic          st_valid;
    logic          st_ready;
    logic [1:0]    st_size;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_wdata;
    logic          st_done;
    logic          st_fault;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_gnt;

    modport slave (
        input  st_valid, st_size, st_addr, st_wdata, mem_gnt,
        output st_ready, st_done, st_fault,
        output mem_req, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output st_valid, st_size, st_addr, st_wdata, mem_gnt,
        input  st_ready, st_done, st_fault,
        input  mem_req, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_align.sv
// Combinational lane alignment: 8-bit enables and 64-bit data over two words.
// split flags that the upper word is touched.
module store_align
    import store_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    output logic [7:0]  o_be8,
    output logic [63:0] o_d64,
    output logic        o_split
);

    assign o_be8   = {4'b0000, size_mask(i_size)} << i_off;
    assign o_d64   = {32'b0, i_wdata} << {i_off, 3'b000};
    assign o_split = |o_be8[7:4];

endmodule

// File: rtl/store_ctrl.sv
// Store sequencer: one store in, one or two data-memory write beats out.
// STORE_CTRL_MISALIGN_SPLIT_EN enables two-beat misaligned stores.
module store_ctrl
    import store_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input logic       clk,
    input logic       rst,
    store_ctrl_if.slave bus
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t        r_state;
    logic          r_req;
    logic          r_done;
    logic          r_fault;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_size;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;

    logic [7:0]    w_be8;
    logic [63:0]   w_d64;
    logic          w_split;
    logic          w_hi;
    logic          w_tmo;
    logic [AW-1:0] w_base;

    store_align u_align (
        .i_size  (r_size),
        .i_off   (r_addr[1:0]),
        .i_wdata (r_wdata),
        .o_be8   (w_be8),
        .o_d64   (w_d64),
        .o_split (w_split)
    );

`ifndef STORE_CTRL_MISALIGN_SPLIT_EN
    logic w_unused_split;
    assign w_unused_split = w_split;
`endif

    assign w_hi   = (r_state == S_BEAT1);
    assign w_base = {r_addr[AW-1:2], 2'b00};
    assign w_tmo  = (TIMEOUT != 0) &&
                    (({1'b0, r_cnt} + (CW+1)'(1)) == (CW+1)'(TIMEOUT));

    assign bus.st_ready  = (r_state == S_IDLE) & ~rst;
    assign bus.st_done   = r_done;
    assign bus.st_fault  = r_fault;
    assign bus.mem_req   = r_req;
    assign bus.mem_addr  = !r_req ? '0 : (w_hi ? w_base + AW'(4) : w_base);
    assign bus.mem_be    = !r_req ? 4'b0 : (w_hi ? w_be8[7:4] : w_be8[3:0]);
    assign bus.mem_wdata = !r_req ? 32'b0 : (w_hi ? w_d64[63:32] : w_d64[31:0]);

    // Request capture, beat sequencing, grant timeout and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= 32'b0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.st_valid) begin
                        r_size  <= bus.st_size;
                        r_addr  <= bus.st_addr;
                        r_wdata <= bus.st_wdata;
                        r_cnt   <= '0;
                        if (bus.st_size == ST_SZ_ILL) begin
                            r_fault <= 1'b1;
                            r_state <= S_RESP;
                        end
`ifndef STORE_CTRL_MISALIGN_SPLIT_EN
                        else if (needs_split(bus.st_size, bus.st_addr[1:0])) begin
                            r_fault <= 1'b1;
                            r_state <= S_RESP;
                        end
`endif
                        else begin
                            r_req   <= 1'b1;
                            r_state <= S_BEAT0;
                        end
                    end
                end
                S_BEAT0, S_BEAT1: begin
                    if (bus.mem_gnt) begin
                        r_cnt <= '0;
`ifdef STORE_CTRL_MISALIGN_SPLIT_EN
                        if (r_state == S_BEAT0 && w_split) begin
                            r_state <= S_BEAT1;
                        end else begin
                            r_req   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_RESP;
                        end
`else
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_RESP;
`endif
                    end else if (w_tmo) begin
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_ctrl.sv
// Testbench for store_ctrl: directed cases plus random stores against a
// byte-level reference model.
module tb_store_ctrl;

    localparam int AW = 32;
    localparam int TO = 4;

`ifdef STORE_CTRL_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    store_ctrl_if #(.AW(AW)) bus ();

    store_ctrl #(
        .AW      (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected beats of the current store.
    logic [31:0] ea [2];
    logic [3:0]  eb [2];
    logic [31:0] ed [2];
    int          enb;
    bit          erej;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lmask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // Byte-by-byte model: each written byte lands in its own word/lane.
    task automatic model(input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd);
        int n;
        logic [31:0] base;
        logic [31:0] a;
        int idx;
        n = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 0;
        base  = addr & ~32'd3;
        ea[0] = base;
        ea[1] = base + 32'd4;
        eb[0] = 4'b0;
        eb[1] = 4'b0;
        ed[0] = 32'b0;
        ed[1] = 32'b0;
        for (int i = 0; i < n; i++) begin
            a   = addr + 32'(i);
            idx = ((a & ~32'd3) == base) ? 0 : 1;
            eb[idx][a[1:0]] = 1'b1;
            ed[idx][8*a[1:0] +: 8] = wd[8*i +: 8];
        end
        enb  = (eb[1] != 4'b0) ? 2 : 1;
        erej = (sz == 2'b11) || (enb == 2 && !SPLIT);
    endtask

    // Presents one store at a negedge and follows it to completion.
    // w0/w1: gnt wait cycles for beat 0/1 (>= TO means timeout).
    task automatic run_store(input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd, input int w0,
                             input int w1);
        int w;
        int cyc;
        bit to;
        model(sz, addr, wd);
        bus.st_valid = 1'b1;
        bus.st_size  = sz;
        bus.st_addr  = addr;
        bus.st_wdata = wd;
        chk("ready_idle", bus.st_ready, 1);
        @(negedge clk);
        bus.st_valid = 1'b0;
        bus.st_size  = 2'($urandom);
        bus.st_addr  = $urandom;
        bus.st_wdata = $urandom;
        if (erej) begin
            bus.mem_gnt = 1'($urandom);
            chk("rej_req", bus.mem_req, 0);
            chk("rej_fault", bus.st_fault, 1);
            chk("rej_done", bus.st_done, 0);
            @(negedge clk);
            bus.mem_gnt = 1'b0;
            chk("rej_fault_end", bus.st_fault, 0);
            chk("rej_ready", bus.st_ready, 1);
            chk("rej_req_end", bus.mem_req, 0);
            return;
        end
        for (int b = 0; b < enb; b++) begin
            w   = (b == 0) ? w0 : w1;
            to  = (w >= TO);
            cyc = to ? TO : w + 1;
            for (int c = 0; c < cyc; c++) begin
                chk("req", bus.mem_req, 1);
                chk("addr", bus.mem_addr, ea[b]);
                chk("be", bus.mem_be, eb[b]);
                chk("wdata", bus.mem_wdata & lmask(eb[b]), ed[b]);
                chk("busy_ready", bus.st_ready, 0);
                chk("busy_done", bus.st_done | bus.st_fault, 0);
                bus.mem_gnt = (!to && c == w);
                @(negedge clk);
                bus.mem_gnt = 1'b0;
            end
            if (to) begin
                chk("to_req", bus.mem_req, 0);
                chk("to_fault", bus.st_fault, 1);
                chk("to_done", bus.st_done, 0);
                @(negedge clk);
                chk("to_ready", bus.st_ready, 1);
                chk("to_fault_end", bus.st_fault, 0);
                return;
            end
        end
        chk("end_req", bus.mem_req, 0);
        chk("done", bus.st_done, 1);
        chk("done_fault", bus.st_fault, 0);
        @(negedge clk);
        chk("done_end", bus.st_done, 0);
        chk("end_ready", bus.st_ready, 1);
    endtask

    initial begin
        logic [1:0] sz;
        int w0;
        int w1;
        bus.st_valid = 1'b0;
        bus.st_size  = 2'b00;
        bus.st_addr  = '0;
        bus.st_wdata = 32'b0;
        bus.mem_gnt  = 1'b0;

        @(negedge clk);
        chk("rst_ready", bus.st_ready, 0);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_done", bus.st_done, 0);
        chk("rst_fault", bus.st_fault, 0);
        chk("rst_be", bus.mem_be, 0);
        chk("rst_addr", bus.mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus.st_ready, 1);

        run_store(2'b00, 32'h100, 32'h11223344, 0, 0);
        run_store(2'b01, 32'h102, 32'h0000BEEF, 0, 0);
        run_store(2'b10, 32'h203, 32'h000000A5, 0, 0);
        run_store(2'b00, 32'h0FE, 32'hAABBCCDD, 0, 0);
        run_store(2'b00, 32'h0FE, 32'hAABBCCDD, 2, 1);
        run_store(2'b11, 32'h100, 32'h12345678, 0, 0);
        run_store(2'b11, 32'h3,   32'h12345678, 0, 0);
        run_store(2'b00, 32'h40,  32'hCAFEF00D, 10, 0);
        run_store(2'b00, 32'h40,  32'hCAFEF00D, 3, 0);
        run_store(2'b01, 32'hFFFFFFFF, 32'h0000ABCD, 0, 0);

        // Reset while the store is in its second beat (or a waiting beat 0).
        bus.st_valid = 1'b1;
        bus.st_size  = 2'b00;
        bus.st_addr  = SPLIT ? 32'h0FE : 32'h100;
        bus.st_wdata = 32'hAABBCCDD;
        @(negedge clk);
        bus.st_valid = 1'b0;
        bus.mem_gnt  = SPLIT;
        @(negedge clk);
        bus.mem_gnt  = 1'b0;
        chk("mid_req", bus.mem_req, 1);
        chk("mid_addr", bus.mem_addr, 32'h100);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", bus.mem_req, 0);
        chk("arst_ready", bus.st_ready, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("arst_pulse", bus.st_done | bus.st_fault, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("arst_rel_ready", bus.st_ready, 1);
        chk("arst_rel_pulse", bus.st_done | bus.st_fault, 0);
        chk("arst_rel_req", bus.mem_req, 0);
        run_store(2'b00, 32'h200, 32'h55667788, 1, 0);

        for (int n = 0; n < 300; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            w0 = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 3);
            w1 = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
            run_store(sz, $urandom, $urandom, w0, w1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
